pll_lock_reset_seq: RTL and testbench

- Sits directly downstream of the Sobel PLL and is clocked by its output clock (142.857 MHz).
- Synchronises the PLL lock flag and debounces it for a fixed number of cycles.
- Releases a set of per-stage active-low resets to the Sobel/super-resolution pipeline in a fixed order, then raises ready.
- Any loss of lock re-asserts every stage reset and counts the event for debug LEDs.

---
 rtl/pll_lock_reset_seq_if.sv | 22 ++
 rtl/pll_lock_reset_seq.sv | 143 ++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_reset_seq_if.sv
// Lock/reset sequencing bundle between the PLL-side sequencer and the pipeline.
// The slave modport is the sequencer's view; master is the consumer/driver side.
interface pll_lock_reset_seq_if #(
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 8
);
  logic               locked_in;
  logic               clear_loss;
  logic [NSTAGES-1:0] rst_n_out;
  logic               ready;
  logic [CNT_W-1:0]   loss_count;

  modport master (
    output locked_in, clear_loss,
    input  rst_n_out, ready, loss_count
  );

  modport slave (
    input  locked_in, clear_loss,
    output rst_n_out, ready, loss_count
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// Synchronises and debounces the PLL lock flag, releases per-stage resets in
// ascending order with a fixed gap, then raises ready; counts lock losses.
module pll_lock_reset_seq #(
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int NSTAGES     = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  pll_lock_reset_seq_if.slave  bus
);

  localparam int DW = $clog2(LOCK_CYCLES);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int SW = $clog2(NSTAGES + 1);

  localparam logic [DW-1:0] DLAST = DW'(LOCK_CYCLES - 1);
  localparam logic [GW-1:0] GLAST = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] SLAST = SW'(NSTAGES);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    DEBOUNCE,
    RELEASE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic               sync1, lk;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [NSTAGES-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               loss_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= bus.locked_in;
      lk    <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WAIT_LOCK;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      gcnt_q  <= gcnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    gcnt_d   = gcnt_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    loss_evt = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        rst_d   = '0;
        ready_d = 1'b0;
        if (lk) begin
          state_d = DEBOUNCE;
          dcnt_d  = DW'(1);
        end
      end

      DEBOUNCE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          state_d = RELEASE;
          dcnt_d  = '0;
          gcnt_d  = '0;
          stage_d = SW'(1);
          rst_d   = NSTAGES'(1);
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      RELEASE, RUN: begin
        if (!lk) begin
          loss_evt = 1'b1;
          state_d  = WAIT_LOCK;
          dcnt_d   = '0;
          gcnt_d   = '0;
          stage_d  = '0;
          rst_d    = '0;
          ready_d  = 1'b0;
        end else if (state_q == RELEASE) begin
          if (gcnt_q == GLAST) begin
            gcnt_d = '0;
            if (stage_q == SLAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              // Shift-OR keeps earlier bits set and releases the next one up.
              rst_d   = rst_q | (NSTAGES'(1) << stage_q);
              stage_d = stage_q + SW'(1);
            end
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
      end

      default: state_d = WAIT_LOCK;
    endcase

    loss_d = loss_q;
    if (bus.clear_loss)
      loss_d = '0;
    else if (loss_evt && (loss_q != '1))
      loss_d = loss_q + CNT_W'(1);
  end

  assign bus.rst_n_out  = rst_q;
  assign bus.ready      = ready_q;
  assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed bring-up/loss/saturation/async-reset
// pins plus randomized lock activity checked every cycle against a run-length model.
module tb_pll_lock_reset_seq;
  localparam int LC = 8;
  localparam int SG = 4;
  localparam int NS = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pll_lock_reset_seq_if #(.NSTAGES(NS), .CNT_W(CW)) bus ();

  pll_lock_reset_seq #(
    .LOCK_CYCLES(LC),
    .STAGE_GAP  (SG),
    .NSTAGES    (NS),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: outputs depend only on how many consecutive edges saw lk=1.
  logic m_s1 = 1'b0, m_lk = 1'b0;
  int   m_run = 0;
  int   m_loss = 0;

  function automatic logic [NS-1:0] exp_rst(input int r);
    int n;
    if (r < LC) return '0;
    n = 1 + (r - LC) / SG;
    if (n > NS) n = NS;
    return NS'((1 << n) - 1);
  endfunction

  function automatic logic exp_ready(input int r);
    return r >= LC + NS * SG;
  endfunction

  always @(posedge clk or negedge resetn) begin
    int r, l;
    if (!resetn) begin
      m_s1   <= 1'b0;
      m_lk   <= 1'b0;
      m_run  <= 0;
      m_loss <= 0;
    end else begin
      r = m_run;
      l = m_loss;
      if (m_lk) begin
        if (r < 100000) r = r + 1;
      end else begin
        if (r >= LC && l < (1 << CW) - 1) l = l + 1;
        r = 0;
      end
      if (bus.clear_loss) l = 0;
      m_run  <= r;
      m_loss <= l;
      m_lk   <= m_s1;
      m_s1   <= bus.locked_in;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_rst_n_out", int'(bus.rst_n_out), int'(exp_rst(m_run)));
    check("cyc_ready", int'(bus.ready), int'(exp_ready(m_run)));
    check("cyc_loss_count", int'(bus.loss_count), m_loss);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until just after the given number of posedges.
  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.locked_in  = 1'b0;
    bus.clear_loss = 1'b0;
    resetn = 1'b0;
    #1;
    check("reset_rst_n_out", int'(bus.rst_n_out), 0);
    check("reset_ready", int'(bus.ready), 0);
    cyc(3);
    resetn = 1'b1;
    cyc(2);

    // Nominal bring-up: next posedge is edge 0.
    bus.locked_in = 1'b1;
    after_edges(9);   // after edge 8
    check("pin_rst_e8", int'(bus.rst_n_out), 0);
    after_edges(1);   // after edge 9
    check("pin_rst_e9", int'(bus.rst_n_out), 1);
    after_edges(3);   // after edge 12
    check("pin_rst_e12", int'(bus.rst_n_out), 1);
    after_edges(1);   // edge 13
    check("pin_rst_e13", int'(bus.rst_n_out), 3);
    after_edges(4);   // edge 17
    check("pin_rst_e17", int'(bus.rst_n_out), 7);
    after_edges(3);   // edge 20
    check("pin_ready_e20", int'(bus.ready), 0);
    after_edges(1);   // edge 21
    check("pin_ready_e21", int'(bus.ready), 1);
    check("pin_loss_e21", int'(bus.loss_count), 0);

    // Lock loss in RUN: cleared on the edge that sees lk low.
    cyc(3);
    bus.locked_in = 1'b0;   // before edge m
    after_edges(2);         // after edge m+1
    check("pin_loss_rst_m1", int'(bus.rst_n_out), 7);
    after_edges(1);         // after edge m+2
    check("pin_loss_rst_m2", int'(bus.rst_n_out), 0);
    check("pin_loss_ready", int'(bus.ready), 0);
    check("pin_loss_cnt1", int'(bus.loss_count), 1);

    // Debounce glitch: no release before 8 clean lk-high cycles.
    cyc(3);
    bus.locked_in = 1'b1;
    cyc(5);
    bus.locked_in = 1'b0;
    cyc(1);
    bus.locked_in = 1'b1;   // before edge 0 of the fresh run
    after_edges(9);
    check("pin_glitch_e8", int'(bus.rst_n_out), 0);
    after_edges(1);
    check("pin_glitch_e9", int'(bus.rst_n_out), 1);
    check("pin_glitch_loss", int'(bus.loss_count), 1);

    // Loss in RELEASE with only bit 0 released.
    cyc(1);
    bus.locked_in = 1'b0;
    after_edges(3);
    check("pin_rel_loss_rst", int'(bus.rst_n_out), 0);
    check("pin_rel_loss_cnt", int'(bus.loss_count), 2);
    // Loss during DEBOUNCE is not counted.
    cyc(1);
    bus.locked_in = 1'b1;
    cyc(5);
    bus.locked_in = 1'b0;
    cyc(4);
    check("pin_deb_loss_cnt", int'(bus.loss_count), 2);

    // Saturation: 2-bit counter stops at 3.
    repeat (3) begin
      bus.locked_in = 1'b1;
      cyc(12);
      bus.locked_in = 1'b0;
      cyc(4);
    end
    check("pin_sat_cnt", int'(bus.loss_count), 3);
    // Clear coincident with another loss wins.
    bus.locked_in = 1'b1;
    cyc(12);
    bus.locked_in = 1'b0;   // loss lands on the third posedge from here
    cyc(2);
    bus.clear_loss = 1'b1;
    cyc(1);
    bus.clear_loss = 1'b0;
    #1;
    check("pin_clear_cnt", int'(bus.loss_count), 0);
    check("pin_clear_rst", int'(bus.rst_n_out), 0);

    // Async reset in RUN: outputs drop without a clock edge.
    bus.locked_in = 1'b1;
    cyc(30);
    check("pin_run_ready", int'(bus.ready), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("pin_async_rst", int'(bus.rst_n_out), 0);
    check("pin_async_ready", int'(bus.ready), 0);
    cyc(2);
    resetn = 1'b1;          // locked_in held high; next posedge is edge 0
    after_edges(9);
    check("pin_restart_e8", int'(bus.rst_n_out), 0);
    after_edges(1);
    check("pin_restart_e9", int'(bus.rst_n_out), 1);

    // Randomized lock activity, clears and occasional async resets.
    for (int i = 0; i < 300; i++) begin
      int unsigned mode;
      cyc(1);
      mode = $urandom_range(0, 9);
      if (mode < 5) begin
        bus.locked_in = 1'b1;
        bus.clear_loss = ($urandom_range(0, 19) == 0);
        cyc($urandom_range(1, 30));
      end else if (mode < 9) begin
        bus.locked_in = 1'b0;
        bus.clear_loss = ($urandom_range(0, 9) == 0);
        cyc($urandom_range(1, 3));
      end else begin
        bus.clear_loss = 1'b0;
        #($urandom_range(1, 8));
        resetn = 1'b0;
        cyc($urandom_range(1, 3));
        resetn = 1'b1;
      end
      bus.clear_loss = 1'b0;
    end

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
